// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core memory stage and the pixel reader.
// Grant is combinational and read data returns one cycle later; the core stalls while denied. Define DMEM_ARB_STATS_EN for stall/pixel-grant counters.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuAddr,
    input  logic [31:0]   cpuWData,
    output logic [31:0]   cpuRData,
    output logic          cpuStall,
    input  logic          pixReq,
    input  logic [AW-1:0] pixAddr,
    output logic [31:0]   pixRData,
    output logic          pixValid,
    output logic [AW-1:0] memAddr,
    output logic [31:0]   memWData,
    output logic          memWe,
    input  logic [31:0]   memRData
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   statStallCnt,
    output logic [15:0]   statPixCnt
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PIX  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    owner_t      rd_owner;
    owner_t      rd_owner_nxt;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;
    logic [31:0] cpu_hold;
    logic [31:0] pix_hold;
    logic        gnt_cpu;
    logic        gnt_pix;

    // Pixel has priority until the core has been denied WAIT_LIM cycles in a row.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_pix = 1'b0;
        if (reset) begin
            gnt_cpu = cpuReq & (~pixReq | (starve_cnt >= WAIT_LIM));
            gnt_pix = pixReq & ~gnt_cpu;
        end
    end

    always_comb begin
        starve_cnt_nxt = 4'd0;
        if (reset && cpuReq && !gnt_cpu) begin
            starve_cnt_nxt = (starve_cnt >= WAIT_LIM) ? WAIT_LIM : starve_cnt + 4'd1;
        end
    end

    // Writes produce no read data, so they leave the owner at NONE.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (gnt_pix) begin
            rd_owner_nxt = OWN_PIX;
        end else if (gnt_cpu && !cpuWe) begin
            rd_owner_nxt = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_owner   <= OWN_NONE;
            starve_cnt <= 4'd0;
            cpu_hold   <= 32'd0;
            pix_hold   <= 32'd0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
            if (rd_owner == OWN_PIX) begin
                pix_hold <= memRData;
            end
            if (rd_owner == OWN_CPU) begin
                cpu_hold <= memRData;
            end
        end
    end

    assign memAddr  = gnt_cpu ? cpuAddr : (gnt_pix ? pixAddr : '0);
    assign memWData = gnt_cpu ? cpuWData : 32'd0;
    assign memWe    = gnt_cpu & cpuWe;
    assign cpuStall = reset & cpuReq & ~gnt_cpu;

    // Live RAM data for the owner; the other side keeps showing its last word.
    assign pixValid = (rd_owner == OWN_PIX);
    assign pixRData = pixValid ? memRData : pix_hold;
    assign cpuRData = (rd_owner == OWN_CPU) ? memRData : cpu_hold;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            statStallCnt <= 16'd0;
            statPixCnt   <= 16'd0;
        end else begin
            if (cpuStall && (statStallCnt != 16'hFFFF)) begin
                statStallCnt <= statStallCnt + 16'd1;
            end
            if (gnt_pix && (statPixCnt != 16'hFFFF)) begin
                statPixCnt <= statPixCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: bench-side RAM, per-cycle reference model, literal checkpoints.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWData;
    logic [31:0] cpuRData;
    logic        cpuStall;
    logic        pixReq;
    logic [31:0] pixAddr;
    logic [31:0] pixRData;
    logic        pixValid;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        memWe;
    logic [31:0] memRData;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] statStallCnt;
    logic [15:0] statPixCnt;
`endif

    int n_tests;
    int n_fail;

    dmem_arbiter #(.MAX_WAIT(MW), .AW(32)) dut (
        .clk(clk),
        .reset(reset),
        .cpuReq(cpuReq),
        .cpuWe(cpuWe),
        .cpuAddr(cpuAddr),
        .cpuWData(cpuWData),
        .cpuRData(cpuRData),
        .cpuStall(cpuStall),
        .pixReq(pixReq),
        .pixAddr(pixAddr),
        .pixRData(pixRData),
        .pixValid(pixValid),
        .memAddr(memAddr),
        .memWData(memWData),
        .memWe(memWe),
        .memRData(memRData)
`ifdef DMEM_ARB_STATS_EN
        ,
        .statStallCnt(statStallCnt),
        .statPixCnt(statPixCnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM, word-indexed, one cycle read latency.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        memRData <= ram[memAddr[9:2]];
        if (memWe) ram[memAddr[9:2]] = memWData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel first, except after MW consecutive denials of the core.
    int          wait_run;
    int          pend;        // 0 none, 1 core read, 2 pixel read
    logic [31:0] pend_data;
    logic [31:0] cpu_hold;
    logic [31:0] pix_hold;
    logic [31:0] shadow [256];
    int          st_stall;
    int          st_pix;

    task automatic model_step();
        logic        egc;
        logic        egp;
        logic        estall;
        logic [31:0] e_addr;
        egc = 1'b0;
        egp = 1'b0;
        if (reset) begin
            egc = cpuReq && (!pixReq || wait_run >= MW);
            egp = pixReq && !egc;
        end
        estall = reset && cpuReq && !egc;
        e_addr = egc ? cpuAddr : (egp ? pixAddr : 32'h0);

        check("memWe", {31'b0, memWe}, {31'b0, egc && cpuWe});
        check("memAddr", memAddr, e_addr);
        check("cpuStall", {31'b0, cpuStall}, {31'b0, estall});
        check("pixValid", {31'b0, pixValid}, {31'b0, pend == 2});
        check("pixRData", pixRData, (pend == 2) ? pend_data : pix_hold);
        check("cpuRData", cpuRData, (pend == 1) ? pend_data : cpu_hold);
        if (egc && cpuWe) check("memWData", memWData, cpuWData);

        if (pend == 2) pix_hold = pend_data;
        if (pend == 1) cpu_hold = pend_data;
        if (!reset) begin
            pix_hold = 32'h0;
            cpu_hold = 32'h0;
            wait_run = 0;
            pend     = 0;
            st_stall = 0;
            st_pix   = 0;
        end else begin
            if (estall) begin
                st_stall++;
                wait_run = (wait_run < MW) ? wait_run + 1 : MW;
            end else begin
                wait_run = 0;
            end
            if (egp) st_pix++;
            pend      = egp ? 2 : ((egc && !cpuWe) ? 1 : 0);
            pend_data = shadow[e_addr[9:2]];
            if (egc && cpuWe) shadow[e_addr[9:2]] = cpuWData;
        end
    endtask

    initial begin
        wait_run  = 0;
        pend      = 0;
        pend_data = 32'h0;
        cpu_hold  = 32'h0;
        pix_hold  = 32'h0;
        st_stall  = 0;
        st_pix    = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'hA000_0000 | 32'(i);
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic pr, input logic [31:0] pa);
        reset    = r;
        cpuReq   = cr;
        cpuWe    = cw;
        cpuAddr  = ca;
        cpuWData = cd;
        pixReq   = pr;
        pixAddr  = pa;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);

        // Reset held with both requesters active
        drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_memWe", {31'b0, memWe}, 32'd0);
            check("rst_stall", {31'b0, cpuStall}, 32'd0);
            check("rst_pixValid", {31'b0, pixValid}, 32'd0);
            adv();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
        @(negedge clk);
        check("rel_pixValid0", {31'b0, pixValid}, 32'd0);
        check("rel_memAddr", memAddr, 32'h100);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rel_pixValid1", {31'b0, pixValid}, 32'd1);
        check("rel_pixData", pixRData, 32'hA000_0040);
        adv();

        // Core write then read-back of the same word
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0);
        @(negedge clk);
        check("wr_memWe", {31'b0, memWe}, 32'd1);
        check("wr_memWData", memWData, 32'hDEADBEEF);
        check("wr_stall", {31'b0, cpuStall}, 32'd0);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_stall", {31'b0, cpuStall}, 32'd0);
        check("rd_memWe", {31'b0, memWe}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_cpuRData", cpuRData, 32'hDEADBEEF);
        adv();

        // Eight back-to-back pixel reads
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100 + 32'(4 * i));
            else       drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", {31'b0, pixValid}, 32'd1);
                check("stream_data", pixRData, 32'hA000_0040 + 32'(i - 1));
            end
            adv();
        end
        @(negedge clk);
        check("stream_end_valid", {31'b0, pixValid}, 32'd0);
        check("stream_hold", pixRData, 32'hA000_0047);
        adv();

        // Starvation: core stalls MW cycles, wins on the next one
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h200);
        for (int i = 1; i <= MW + 1; i++) begin
            @(negedge clk);
            if (i <= MW) begin
                check("starve_stall", {31'b0, cpuStall}, 32'd1);
            end else begin
                check("starve_grant_stall", {31'b0, cpuStall}, 32'd0);
                check("starve_grant_addr", memAddr, 32'h80);
            end
            adv();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        @(negedge clk);
        check("resume_pixValid", {31'b0, pixValid}, 32'd0);
        check("resume_addr", memAddr, 32'h200);
        check("starve_cpuRData", cpuRData, 32'hA000_0020);
        adv();

        // Pixel drops after two denials: core granted in that same cycle
        drive(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b1, 32'h204);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop_stall", {31'b0, cpuStall}, 32'd1);
            adv();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("drop_stall_low", {31'b0, cpuStall}, 32'd0);
        check("drop_addr", memAddr, 32'h84);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("drop_cpuRData", cpuRData, 32'hA000_0021);
        adv();

        // Reset in the middle of traffic clears the returned-data registers
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
        @(negedge clk);
        adv();
        drive(1'b0, 1'b1, 1'b1, 32'h48, 32'h55, 1'b1, 32'h108);
        @(negedge clk);
        check("mid_rst_memWe", {31'b0, memWe}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("mid_rst_pixValid", {31'b0, pixValid}, 32'd0);
        check("mid_rst_cpuRData", cpuRData, 32'h0);
        check("mid_rst_pixRData", pixRData, 32'h0);
        adv();

        // Three starvation rounds: 12 stalls and 12 pixel grants in total
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 1'b1, 32'h20C);
            for (int i = 0; i <= MW; i++) begin
                @(negedge clk);
                adv();
            end
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
            check("rep_cpuRData", cpuRData, 32'hA000_0022);
            adv();
        end
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        check("stat_stall", {16'b0, statStallCnt}, 32'd12);
        check("stat_pix", {16'b0, statPixCnt}, 32'd12);
        check("stat_stall_model", {16'b0, statStallCnt}, 32'(st_stall));
        check("stat_pix_model", {16'b0, statPixCnt}, 32'(st_pix));
        adv();
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
